// File: rtl/pwm_compare.sv
// PWM comparator fed by a free-running counter, with double-buffered duty applied only at count wraps.
// Optional completed-period counter is enabled by defining PWM_PERIOD_CNT_EN.
module pwm_compare #(
    parameter int WIDTH = 8
`ifdef PWM_PERIOD_CNT_EN
    ,
    parameter int PCNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             res,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_wr,
    output logic             duty_busy,
    output logic             pwm_out,
    output logic             wrap_pulse,
    output logic             match_pulse,
`ifdef PWM_PERIOD_CNT_EN
    output logic [PCNT_W-1:0] period_cnt,
`endif
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_prev_q;
    logic [WIDTH-1:0] duty_act_q;
    logic [WIDTH-1:0] duty_pend_q;
    logic             duty_busy_q;
    logic             pwm_q, wrap_q, match_q;
    logic             pwm_d, wrap_d, match_d;

    logic             wrap;
    logic             armed;
    logic             apply;
    logic             run_active;
    logic [WIDTH-1:0] duty_eff;

    // A backward step of the count (rollover or upstream reset) marks a period boundary.
    assign wrap       = (cnt_in < cnt_prev_q);
    assign armed      = (state_q == SYNC) || (state_q == RUN);
    assign apply      = wrap && duty_busy_q && armed;
    assign duty_eff   = (wrap && duty_busy_q) ? duty_pend_q : duty_act_q;
    assign run_active = en && ((state_q == RUN) || ((state_q == SYNC) && wrap));

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (en) state_d = SYNC;
            SYNC:    if (!en) state_d = IDLE;
                     else if (wrap) state_d = RUN;
            RUN:     if (!en) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pwm_d   = 1'b0;
        match_d = 1'b0;
        wrap_d  = 1'b0;
        if (run_active) begin
            pwm_d   = (cnt_in < duty_eff);
            match_d = (cnt_in == duty_eff);
        end
        if (en && armed) begin
            wrap_d = wrap;
        end
    end

    // A write in the wrap cycle lands in duty_pend while the old pending value moves to duty_act.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt_prev_q  <= '0;
            duty_act_q  <= '0;
            duty_pend_q <= '0;
            duty_busy_q <= 1'b0;
            pwm_q       <= 1'b0;
            wrap_q      <= 1'b0;
            match_q     <= 1'b0;
        end else begin
            cnt_prev_q <= cnt_in;
            pwm_q      <= pwm_d;
            wrap_q     <= wrap_d;
            match_q    <= match_d;
            if (apply) begin
                duty_act_q <= duty_pend_q;
            end
            if (duty_wr) begin
                duty_pend_q <= duty_in;
                duty_busy_q <= 1'b1;
            end else if (apply) begin
                duty_busy_q <= 1'b0;
            end
        end
    end

`ifdef PWM_PERIOD_CNT_EN
    logic [PCNT_W-1:0] period_cnt_q;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            period_cnt_q <= '0;
        end else if ((state_q == RUN) && wrap && (period_cnt_q != {PCNT_W{1'b1}})) begin
            period_cnt_q <= period_cnt_q + 1'b1;
        end
    end

    assign period_cnt = period_cnt_q;
`endif

    assign duty_busy   = duty_busy_q;
    assign pwm_out     = pwm_q;
    assign wrap_pulse  = wrap_q;
    assign match_pulse = match_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pwm_compare.sv
// Self-checking bench for pwm_compare: directed period scenarios plus random traffic against a cycle reference model.
module tb_pwm_compare;

    logic       clk;
    logic       res;
    logic [7:0] cnt;
    logic       en;
    logic [7:0] duty_in;
    logic       duty_wr;
    logic       duty_busy, pwm_out, wrap_pulse, match_pulse;
    logic [1:0] dbg_state;
`ifdef PWM_PERIOD_CNT_EN
    logic [15:0] period_cnt;
`endif

    pwm_compare dut (
        .clk         (clk),
        .res         (res),
        .cnt_in      (cnt),
        .en          (en),
        .duty_in     (duty_in),
        .duty_wr     (duty_wr),
        .duty_busy   (duty_busy),
        .pwm_out     (pwm_out),
        .wrap_pulse  (wrap_pulse),
        .match_pulse (match_pulse),
`ifdef PWM_PERIOD_CNT_EN
        .period_cnt  (period_cnt),
`endif
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: 0 = idle, 1 = waiting for a period boundary, 2 = running.
    int         m_state;
    logic [7:0] m_prev, m_act, m_pend;
    logic       m_busy, m_pwm, m_wrap, m_match;
    int         m_pc;
    int         hi_acc;
    bit         free_run;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_prev  = 8'd0;
        m_act   = 8'd0;
        m_pend  = 8'd0;
        m_busy  = 1'b0;
        m_pwm   = 1'b0;
        m_wrap  = 1'b0;
        m_match = 1'b0;
        m_pc    = 0;
    endtask

    task automatic tick();
        bit         w, active;
        int         eff, n_state;
        w      = (int'(cnt) < int'(m_prev));
        eff    = (w && m_busy) ? int'(m_pend) : int'(m_act);
        active = en && (m_state == 2 || (m_state == 1 && w));
        n_state = m_state;
        if (m_state == 0 && en) n_state = 1;
        else if (m_state == 1) n_state = !en ? 0 : (w ? 2 : 1);
        else if (m_state == 2 && !en) n_state = 0;
        @(posedge clk);
        #1;
        if (m_state == 2 && w && m_pc < 65535) m_pc++;
        if (w && m_busy && m_state != 0) begin
            m_act = m_pend;
            if (!duty_wr) m_busy = 1'b0;
        end
        if (duty_wr) begin
            m_pend = duty_in;
            m_busy = 1'b1;
        end
        m_pwm   = active && (int'(cnt) < eff);
        m_match = active && (int'(cnt) == eff);
        m_wrap  = en && w && (m_state != 0);
        m_prev  = cnt;
        m_state = n_state;
        check("pwm_out", pwm_out, m_pwm);
        check("match_pulse", match_pulse, m_match);
        check("wrap_pulse", wrap_pulse, m_wrap);
        check("duty_busy", duty_busy, m_busy);
        check("state", dbg_state, m_state);
`ifdef PWM_PERIOD_CNT_EN
        check("period_cnt", period_cnt, m_pc);
`endif
        hi_acc += int'(pwm_out);
        if (free_run) cnt = cnt + 8'd1;
    endtask

    task automatic write_duty(input logic [7:0] d);
        duty_wr = 1'b1;
        duty_in = d;
        tick();
        duty_wr = 1'b0;
    endtask

    task automatic align_to(input logic [7:0] v);
        int n = 0;
        while (cnt != v && n < 300) begin
            tick();
            n++;
        end
        check("align", cnt, v);
    endtask

    // One full period starting with the edge that samples cnt_in = 0.
    task automatic run_period(input int exp_hi, input bit wr_first, input logic [7:0] wr_val);
        check("period_start", cnt, 0);
        hi_acc = 0;
        if (wr_first) begin
            duty_wr = 1'b1;
            duty_in = wr_val;
        end
        tick();
        duty_wr = 1'b0;
        if (wr_first) check("busy_across_wrap", duty_busy, 1);
        repeat (255) tick();
        check("period_hi", hi_acc, exp_hi);
    endtask

    initial begin
        res      = 1'b0;
        en       = 1'b1;
        duty_wr  = 1'b1;
        duty_in  = 8'd0;
        cnt      = 8'd0;
        free_run = 1'b0;
        hi_acc   = 0;
        model_reset();

        // Reset held for 17 ns with en and duty_wr active.
        #6;
        check("rst_pwm", pwm_out, 0);
        check("rst_busy", duty_busy, 0);
        check("rst_state", dbg_state, 0);
        #10;
        check("rst_pwm2", pwm_out, 0);
        check("rst_wrap", wrap_pulse, 0);
        check("rst_match", match_pulse, 0);
        check("rst_busy2", duty_busy, 0);
        #1 res = 1'b1;
        #3;
        check("post_rst_busy", duty_busy, 0);
        tick();
        check("post_rst_state_sync", dbg_state, 1);
        check("post_rst_busy_rise", duty_busy, 1);

        // Basic PWM at duty 64, written while idle.
        duty_wr = 1'b0;
        en      = 1'b0;
        tick();
        write_duty(8'd64);
        cnt      = 8'd250;
        free_run = 1'b1;
        en       = 1'b1;
        align_to(8'd0);
        check("busy_before_wrap", duty_busy, 1);
        run_period(64, 1'b0, 8'd0);
        check("busy_after_apply", duty_busy, 0);

        // Extremes.
        align_to(8'd10);
        write_duty(8'd0);
        align_to(8'd0);
        run_period(0, 1'b0, 8'd0);
        align_to(8'd10);
        write_duty(8'd255);
        align_to(8'd0);
        run_period(255, 1'b0, 8'd0);

        // Last write wins; current period is unaffected.
        align_to(8'd30);
        write_duty(8'd100);
        align_to(8'd40);
        write_duty(8'd200);
        align_to(8'd0);
        run_period(200, 1'b0, 8'd0);

        // Write coinciding with a wrap stays pending for the following wrap.
        align_to(8'd100);
        write_duty(8'd77);
        align_to(8'd0);
        run_period(77, 1'b1, 8'd50);
        run_period(50, 1'b0, 8'd0);

        // Enable drop and re-assert mid-period.
        align_to(8'd50);
        en = 1'b0;
        tick();
        check("en_drop_pwm", pwm_out, 0);
        align_to(8'd80);
        en = 1'b1;
        align_to(8'd0);
        run_period(50, 1'b0, 8'd0);

        // Upstream counter reset at 120 is a wrap.
        align_to(8'd110);
        write_duty(8'd33);
        align_to(8'd120);
        tick();
        cnt = 8'd0;
        tick();
        check("jump_wrap_pulse", wrap_pulse, 1);
        check("jump_busy_cleared", duty_busy, 0);
        align_to(8'd0);
        run_period(33, 1'b0, 8'd0);

        // Random traffic.
        for (int i = 0; i < 800; i++) begin
            duty_wr = ($urandom_range(0, 19) == 0);
            duty_in = 8'($urandom);
            if ($urandom_range(0, 149) == 0) en = ~en;
            if ($urandom_range(0, 199) == 0) cnt = 8'($urandom_range(0, 255));
            tick();
        end
        duty_wr = 1'b0;
        en      = 1'b1;

        // Asynchronous reset while running with the output high.
        write_duty(8'd200);
        align_to(8'd0);
        align_to(8'd0);
        align_to(8'd10);
        check("pre_async_pwm", pwm_out, 1);
        #2 res = 1'b0;
        #1;
        check("async_pwm", pwm_out, 0);
        check("async_busy", duty_busy, 0);
        check("async_state", dbg_state, 0);
        model_reset();
        @(negedge clk);
        res = 1'b1;
        repeat (20) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
